// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// datapath select codes and the packed control word driven by the decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// Combinational state -> control word decoder (Moore outputs of the main FSM).
// Unused state encodings decode to an all-zero word.
module control_output_decode
    import mips_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            // Branch target is precomputed here while the opcode is decoded.
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMMSH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main control FSM of the multicycle MIPS: state register plus next-state logic;
// all datapath controls come from the registered state through the decoder.
module control_unit
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR; anything other than lw is a store.
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    control_output_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign PCWrite  = ctrl.pc_write;
    assign Branch   = ctrl.branch;
    assign IorD     = ctrl.iord;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSrc    = ctrl.pc_src;
    assign ALUOp    = ctrl.alu_op;
    assign state    = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks every instruction class through the FSM
// and compares state plus the full control word against hand-written constants.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic [3:0] state;

    logic [3:0]  dec_state;
    logic [14:0] dec_word;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Word layout: PCWrite Branch IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB PCSrc ALUOp
    localparam logic [14:0] W_FETCH   = 15'b1_0_0_0_1_0_0_0_0_01_00_00;
    localparam logic [14:0] W_DECODE  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [14:0] W_MEMADR  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] W_MEMRD   = 15'b0_0_1_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] W_MEMWB   = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [14:0] W_MEMWR   = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
    localparam logic [14:0] W_EXECUTE = 15'b0_0_0_0_0_0_0_0_1_00_00_10;
    localparam logic [14:0] W_ALUWB   = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [14:0] W_BRANCH  = 15'b0_1_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] W_ADDIEX  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] W_ADDIWB  = 15'b0_0_0_0_0_0_0_1_0_00_00_00;
    localparam logic [14:0] W_JUMP    = 15'b1_0_0_0_0_0_0_0_0_00_10_00;

    logic [14:0] word;
    assign word = {PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, PCSrc, ALUOp};

    control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .PCWrite  (PCWrite),
        .Branch   (Branch),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCSrc    (PCSrc),
        .ALUOp    (ALUOp),
        .state    (state)
    );

    // Standalone decoder instance to exercise the unused state encodings.
    mips_pkg::ctrl_t dec_ctrl;
    control_output_decode u_dec (
        .state_i (dec_state),
        .ctrl_o  (dec_ctrl)
    );
    assign dec_word = dec_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp_state, input logic [14:0] exp_word);
        chk({tag, ".state"}, {11'd0, state}, {11'd0, exp_state});
        chk({tag, ".ctrl"}, word, exp_word);
    endtask

    initial begin
        reset = 1'b1;
        op = 6'($urandom);
        step();
        step();
        reset = 1'b0;
        chk_st("reset", 4'd0, W_FETCH);

        // lw: 0,1,2,3,4,0; op change during MEMRD must be ignored
        op = 6'b100011;
        step(); chk_st("lw.decode", 4'd1, W_DECODE);
        step(); chk_st("lw.memadr", 4'd2, W_MEMADR);
        step(); chk_st("lw.memrd", 4'd3, W_MEMRD);
        op = 6'b000100;
        step(); chk_st("lw.memwb", 4'd4, W_MEMWB);
        step(); chk_st("lw.fetch", 4'd0, W_FETCH);

        // sw then R-type back to back
        op = 6'b101011;
        step(); chk_st("sw.decode", 4'd1, W_DECODE);
        step(); chk_st("sw.memadr", 4'd2, W_MEMADR);
        step(); chk_st("sw.memwr", 4'd5, W_MEMWR);
        step(); chk_st("sw.fetch", 4'd0, W_FETCH);
        op = 6'b000000;
        step(); chk_st("r.decode", 4'd1, W_DECODE);
        step(); chk_st("r.execute", 4'd6, W_EXECUTE);
        step(); chk_st("r.aluwb", 4'd7, W_ALUWB);
        step(); chk_st("r.fetch", 4'd0, W_FETCH);

        // beq
        op = 6'b000100;
        step(); chk_st("beq.decode", 4'd1, W_DECODE);
        step(); chk_st("beq.branch", 4'd8, W_BRANCH);
        step(); chk_st("beq.fetch", 4'd0, W_FETCH);

        // addi
        op = 6'b001000;
        step(); chk_st("addi.decode", 4'd1, W_DECODE);
        step(); chk_st("addi.ex", 4'd9, W_ADDIEX);
        step(); chk_st("addi.wb", 4'd10, W_ADDIWB);
        step(); chk_st("addi.fetch", 4'd0, W_FETCH);

        // j
        op = 6'b000010;
        step(); chk_st("j.decode", 4'd1, W_DECODE);
        step(); chk_st("j.jump", 4'd11, W_JUMP);
        step(); chk_st("j.fetch", 4'd0, W_FETCH);

        // invalid opcode behaves as a two-cycle NOP
        op = 6'b111111;
        step(); chk_st("inv.decode", 4'd1, W_DECODE);
        step(); chk_st("inv.fetch", 4'd0, W_FETCH);

        // reset while in MEMWR cancels the store
        op = 6'b101011;
        step(); chk_st("swr.decode", 4'd1, W_DECODE);
        step(); chk_st("swr.memadr", 4'd2, W_MEMADR);
        step(); chk_st("swr.memwr", 4'd5, W_MEMWR);
        reset = 1'b1;
        step(); chk_st("swr.reset", 4'd0, W_FETCH);
        chk("swr.memwrite", {14'd0, MemWrite}, 15'd0);
        reset = 1'b0;
        op = 6'b001000;
        step(); chk_st("post.decode", 4'd1, W_DECODE);
        step(); chk_st("post.ex", 4'd9, W_ADDIEX);
        step(); chk_st("post.wb", 4'd10, W_ADDIWB);
        step(); chk_st("post.fetch", 4'd0, W_FETCH);

        // unused encodings decode to all-zero controls
        for (int s = 12; s < 16; s++) begin
            dec_state = 4'(s);
            #1;
            chk($sformatf("unused.%0d", s), dec_word, 15'd0);
        end
        dec_state = 4'd8;
        #1;
        chk("dec.branch", dec_word, W_BRANCH);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
